// File: rtl/matvec8_pkg.sv
// Shared constants and state encoding for the 8x8 streaming matrix-vector multiplier.
package matvec8_pkg;
    localparam int K  = 8;
    localparam int IW = 14;
    localparam int OW = 28;
    localparam int CW = 3;
    localparam int MW = 6;

    typedef enum logic [1:0] {LOAD_M, LOAD_X, MAC, OUT} state_t;
endpackage

// File: rtl/matvec8_part4_if.sv
// Producer-side input stream and consumer-side output stream of matvec8_part4.
interface matvec8_part4_if;
    import matvec8_pkg::*;

    logic          input_valid;
    logic          input_ready;
    logic [IW-1:0] input_data;
    logic          new_matrix;
    logic          output_valid;
    logic          output_ready;
    logic [OW-1:0] output_data;

    modport master (
        output input_valid, input_data, new_matrix, output_ready,
        input  input_ready, output_valid, output_data
    );
    modport slave (
        input  input_valid, input_data, new_matrix, output_ready,
        output input_ready, output_valid, output_data
    );
endinterface

// File: rtl/matvec8_mac.sv
// Signed 14x14 multiply feeding a 28-bit wrapping accumulator; o_sum is the would-be next value.
module matvec8_mac
    import matvec8_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [IW-1:0] i_a,
    input  logic signed [IW-1:0] i_b,
    output logic signed [OW-1:0] o_sum
);
    logic signed [OW-1:0] r_acc;
    logic signed [OW-1:0] w_prod;

    // Full product fits OW bits exactly; the sum wraps modulo 2^OW.
    assign w_prod = OW'(i_a) * OW'(i_b);
    assign o_sum  = r_acc + w_prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= o_sum;
    end
endmodule

// File: rtl/matvec8_part4.sv
// Streaming 8x8 signed matrix-vector multiplier: FSM, matrix/vector register files, output register.
module matvec8_part4
    import matvec8_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    matvec8_part4_if.slave bus
);
    state_t               r_state, w_nstate;
    logic                 r_first;
    logic [MW-1:0]        r_midx;
    logic [CW-1:0]        r_col, r_row;
    logic signed [IW-1:0] r_mat [K*K];
    logic signed [IW-1:0] r_vec [K];
    logic signed [OW-1:0] r_out, w_sum;
    logic                 w_in_rdy, w_out_vld, w_in_fire, w_out_fire, w_clr, w_en;

    assign w_in_fire        = bus.input_valid && w_in_rdy;
    assign w_out_fire       = w_out_vld && bus.output_ready;
    assign bus.input_ready  = w_in_rdy;
    assign bus.output_valid = w_out_vld;
    assign bus.output_data  = r_out;

    matvec8_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_en  (w_en),
        .i_a   (r_mat[{r_row, r_col}]),
        .i_b   (r_vec[r_col]),
        .o_sum (w_sum)
    );

    always_comb begin
        w_nstate  = r_state;
        w_in_rdy  = 1'b0;
        w_out_vld = 1'b0;
        w_clr     = 1'b0;
        w_en      = 1'b0;
        case (r_state)
            LOAD_X: begin
                w_in_rdy = 1'b1;
                if (bus.input_valid) begin
                    if (r_first && bus.new_matrix) begin
                        w_nstate = LOAD_M;
                    end else if (r_col == CW'(K-1)) begin
                        w_nstate = MAC;
                        w_clr    = 1'b1;
                    end
                end
            end
            LOAD_M: begin
                w_in_rdy = 1'b1;
                if (bus.input_valid && r_midx == MW'(K*K-1)) w_nstate = LOAD_X;
            end
            MAC: begin
                w_en = 1'b1;
                if (r_col == CW'(K-1)) w_nstate = OUT;
            end
            OUT: begin
                w_out_vld = 1'b1;
                if (bus.output_ready) begin
                    w_clr    = 1'b1;
                    w_nstate = (r_row == CW'(K-1)) ? LOAD_X : MAC;
                end
            end
            default: w_nstate = LOAD_X;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD_X;
            r_first <= 1'b1;
            r_midx  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_out   <= '0;
            for (int i = 0; i < K*K; i++) r_mat[i] <= '0;
            for (int i = 0; i < K; i++)   r_vec[i] <= '0;
        end else begin
            r_state <= w_nstate;
            case (r_state)
                LOAD_X: if (w_in_fire) begin
                    r_first <= 1'b0;
                    if (r_first && bus.new_matrix) begin
                        r_mat[0] <= bus.input_data;
                        r_midx   <= MW'(1);
                    end else begin
                        r_vec[r_col] <= bus.input_data;
                        r_col        <= r_col + CW'(1);
                        r_row        <= '0;
                    end
                end
                LOAD_M: if (w_in_fire) begin
                    r_mat[r_midx] <= bus.input_data;
                    r_midx        <= r_midx + MW'(1);
                end
                MAC: begin
                    r_col <= r_col + CW'(1);
                    // Capture the finished row on its last product so OUT can present it stably.
                    if (r_col == CW'(K-1)) r_out <= w_sum;
                end
                OUT: if (w_out_fire) begin
                    r_row <= r_row + CW'(1);
                    if (r_row == CW'(K-1)) r_first <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matvec8_part4.sv
// Scoreboard bench: stimulus pushes expected dot products, a monitor pops and compares on each output handshake.
module tb_matvec8_part4;
    import matvec8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matvec8_part4_if bus();
    matvec8_part4 dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [OW-1:0] expq[$];
    int gm[64];
    int nm_mat[64];
    int xv[8];
    bit in_stall = 0, out_stall = 0, chk_lat = 0;
    int t_ref = 0;

    // Reference: plain integer dot product, reduced modulo 2^28.
    function automatic logic [OW-1:0] dot(int r);
        longint s = 0;
        for (int c = 0; c < 8; c++) s += longint'(gm[r*8+c]) * longint'(xv[c]);
        return s[OW-1:0];
    endfunction

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.input_valid = 1'b0;
        bus.input_data  = 'x;
        bus.new_matrix  = 1'bx;
    endtask

    // Starts and ends on a negedge; leaves the word driven so the next call can follow back-to-back.
    task automatic send_word(int v, bit nm, bit last);
        int guard = 0;
        while (in_stall && $urandom_range(1, 0) == 1) begin
            idle_inputs();
            @(negedge clk);
        end
        bus.input_valid = 1'b1;
        bus.input_data  = IW'(v);
        bus.new_matrix  = nm;
        while (!bus.input_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL input_timeout: got ready=0 expected ready=1 within 3000 cycles");
        end
        if (last) t_ref = cyc + 1;
        @(negedge clk);
    endtask

    // rest: new_matrix value on non-first words (0, 1, or 2 = random).
    task automatic run_set(bit nm, int rest);
        int n, v;
        bit b;
        if (nm) gm = nm_mat;
        for (int r = 0; r < 8; r++) expq.push_back(dot(r));
        n = nm ? 72 : 8;
        for (int i = 0; i < n; i++) begin
            v = (nm && i < 64) ? nm_mat[i] : xv[i - (nm ? 64 : 0)];
            b = (i == 0) ? nm : ((rest == 2) ? bit'($urandom_range(1, 0)) : bit'(rest));
            send_word(v, b, i == n - 1);
        end
        idle_inputs();
    endtask

    task automatic drain();
        int g = 0;
        while (expq.size() != 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d results outstanding expected 0", expq.size());
            expq.delete();
        end
        @(negedge clk);
    endtask

    function automatic int rnd14();
        return int'($urandom_range(16383, 0)) - 8192;
    endfunction

    // Monitor: output handshakes, hold-while-stalled, latency and ready-after-y7.
    initial begin
        bit pv = 0, pr = 0, chk_rdy = 0;
        logic [OW-1:0] pd = '0;
        logic [OW-1:0] e;
        int idx = 0;
        bus.output_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 0; idx = 0; chk_rdy = 0;
                continue;
            end
            if (chk_rdy) begin
                check("ready_after_y7", bus.input_ready, 1);
                chk_rdy = 0;
            end
            if (pv && !pr) begin
                check("hold_valid", bus.output_valid, 1);
                check("hold_data", bus.output_data, pd);
            end
            bus.output_ready = out_stall ? logic'($urandom_range(1, 0)) : 1'b1;
            if (bus.output_valid && bus.output_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected no output", $signed(bus.output_data));
                end else begin
                    e = expq.pop_front();
                    check("y", longint'($signed(bus.output_data)), longint'($signed(e)));
                end
                if (chk_lat) check("latency", cyc + 1 - t_ref, 9);
                t_ref = cyc + 1;
                if (idx == 7) begin chk_rdy = 1; idx = 0; end
                else idx++;
            end
            pv = bus.output_valid;
            pr = bus.output_ready;
            pd = bus.output_data;
        end
    end

    initial begin
        idle_inputs();
        foreach (gm[i]) gm[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.output_valid, 0);
        check("rst_data", bus.output_data, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.input_ready, 1);

        // Identity matrix, x = 1..8, exact latency
        for (int i = 0; i < 64; i++) nm_mat[i] = (i / 8 == i % 8) ? 1 : 0;
        for (int c = 0; c < 8; c++) xv[c] = c + 1;
        chk_lat = 1;
        run_set(1, 0);
        drain();

        // Vector-only reuse of the stored identity
        xv = '{2, 0, 0, 0, 0, 0, 0, 0};
        run_set(0, 0);
        drain();

        // new_matrix held high on every non-first word must be ignored
        for (int c = 0; c < 8; c++) xv[c] = rnd14();
        run_set(0, 1);
        drain();

        // Wrap corners
        foreach (nm_mat[i]) nm_mat[i] = -8192;
        foreach (xv[i]) xv[i] = -8192;
        run_set(1, 2);
        drain();
        foreach (nm_mat[i]) nm_mat[i] = 8191;
        foreach (xv[i]) xv[i] = 8191;
        run_set(1, 2);
        drain();
        chk_lat = 0;

        // Random stall stress
        in_stall = 1;
        out_stall = 1;
        for (int s = 0; s < 700; s++) begin
            bit nm;
            nm = ($urandom_range(99, 0) < 15);
            if (nm) foreach (nm_mat[i]) nm_mat[i] = rnd14();
            foreach (xv[i]) xv[i] = rnd14();
            run_set(nm, 2);
        end
        drain();
        in_stall = 0;
        out_stall = 0;

        // Reset mid-matrix clears storage
        foreach (nm_mat[i]) nm_mat[i] = rnd14();
        for (int i = 0; i < 30; i++) send_word(nm_mat[i], i == 0, 0);
        idle_inputs();
        reset = 1'b0;
        foreach (gm[i]) gm[i] = 0;
        expq.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_valid", bus.output_valid, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 8; c++) xv[c] = c + 1;
        run_set(0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
